// File: rtl/tpu_job_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_sched_pkg
//  Description : Shared types and constants for the TPU job scheduler:
//                FSM state encoding, completion status codes, datapath
//                widths and a saturating increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_sched_pkg;

    // GEMM dimension width (K, M, N) and perf counter width
    localparam int c_dim_w  = 8;
    localparam int c_perf_w = 24;

    // Completion status codes
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ZERO    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_RUN      = 3'd3,
        S_DONE     = 3'd4
    } sched_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [c_perf_w-1:0] sat_inc(input logic [c_perf_w-1:0] v);
        return (&v) ? v : v + c_perf_w'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_job_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_job_sched_if
//  Description : Bundles the host command channel, the TPU start/busy
//                channel, the completion record channel and status outputs
//                of the job scheduler. 'slave' is the scheduler's view,
//                'master' is the surrounding system's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tpu_job_sched_if #(
    parameter int CMD_DEPTH = 4,
    parameter int TAG_W     = 4
);
    // Host command channel
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [7:0]                   cmd_k;
    logic [7:0]                   cmd_m;
    logic [7:0]                   cmd_n;
    logic [TAG_W-1:0]             cmd_tag;
    // TPU job start / busy
    logic                         tpu_in_valid;
    logic [7:0]                   tpu_k;
    logic [7:0]                   tpu_m;
    logic [7:0]                   tpu_n;
    logic                         tpu_busy;
    // Completion records
    logic                         done_valid;
    logic                         done_ready;
    logic [TAG_W-1:0]             done_tag;
    logic [1:0]                   done_status;
    logic [23:0]                  done_cycles;
    // Status
    logic [$clog2(CMD_DEPTH):0]   pending;
    logic                         sched_idle;

    modport slave (
        input  cmd_valid, cmd_k, cmd_m, cmd_n, cmd_tag,
        output cmd_ready,
        output tpu_in_valid, tpu_k, tpu_m, tpu_n,
        input  tpu_busy,
        output done_valid, done_tag, done_status, done_cycles,
        input  done_ready,
        output pending, sched_idle
    );

    modport master (
        output cmd_valid, cmd_k, cmd_m, cmd_n, cmd_tag,
        input  cmd_ready,
        input  tpu_in_valid, tpu_k, tpu_m, tpu_n,
        output tpu_busy,
        input  done_valid, done_tag, done_status, done_cycles,
        output done_ready,
        input  pending, sched_idle
    );

endinterface
`default_nettype wire

// File: rtl/tpu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_cmd_fifo
//  Description : Synchronous first-word-fall-through FIFO with occupancy
//                count. Holds packed {tag, n, m, k} job commands.
//                DEPTH must be a power of two so pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module tpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; left unreset so it can map onto plain registers/RAM
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count as is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tpu_job_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_job_sched
//  Description : Command-queue front end for the TPU matrix engine. Queues
//                host GEMM jobs, launches them one at a time, watches
//                tpu_busy for acknowledge/completion and returns one in-order
//                completion record per job.
//                Optional build macro TPU_SCHED_PERF_EN adds a 24-bit
//                launch-to-completion cycle counter reported in done_cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tpu_job_sched
    import tpu_sched_pkg::*;
#(
    parameter int CMD_DEPTH   = 4,
    parameter int TAG_W       = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    tpu_job_sched_if.slave  bus
);
    localparam int c_fifo_w = TAG_W + 3 * c_dim_w;
    localparam int c_cnt_w  = $clog2(CMD_DEPTH) + 1;
    localparam int c_ack_w  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_ack_w-1:0] c_ack_last = c_ack_w'(ACK_TIMEOUT - 1);

    sched_state_t          r_state;
    sched_state_t          w_next_state;
    logic                  w_pop;
    logic                  w_enter_done;
    logic [1:0]            w_done_status;

    logic [c_fifo_w-1:0]   w_fifo_wdata;
    logic [c_fifo_w-1:0]   w_fifo_rdata;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_cnt_w-1:0]    w_fifo_count;
    logic                  w_push;

    logic [c_dim_w-1:0]    w_head_k;
    logic [c_dim_w-1:0]    w_head_m;
    logic [c_dim_w-1:0]    w_head_n;
    logic [TAG_W-1:0]      w_head_tag;
    logic                  w_head_zero;

    logic [c_dim_w-1:0]    r_tpu_k;
    logic [c_dim_w-1:0]    r_tpu_m;
    logic [c_dim_w-1:0]    r_tpu_n;
    logic [TAG_W-1:0]      r_job_tag;
    logic [TAG_W-1:0]      r_done_tag;
    logic [1:0]            r_done_status;
    logic [c_ack_w-1:0]    r_ack_cnt;

    assign w_push       = bus.cmd_valid && !w_fifo_full;
    assign w_fifo_wdata = {bus.cmd_tag, bus.cmd_n, bus.cmd_m, bus.cmd_k};
    assign {w_head_tag, w_head_n, w_head_m, w_head_k} = w_fifo_rdata;
    assign w_head_zero  = (w_head_k == '0) || (w_head_m == '0) || (w_head_n == '0);

    tpu_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (c_fifo_w)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_fifo_wdata),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a job is only popped from IDLE, so a pending
    // completion record always blocks the next launch
    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_enter_done  = 1'b0;
        w_done_status = ST_OK;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head_zero) begin
                        w_next_state  = S_DONE;
                        w_enter_done  = 1'b1;
                        w_done_status = ST_ZERO;
                    end else begin
                        w_next_state = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                w_next_state = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.tpu_busy) begin
                    w_next_state = S_RUN;
                end else if (r_ack_cnt == c_ack_last) begin
                    w_next_state  = S_DONE;
                    w_enter_done  = 1'b1;
                    w_done_status = ST_TIMEOUT;
                end
            end
            S_RUN: begin
                if (!bus.tpu_busy) begin
                    w_next_state  = S_DONE;
                    w_enter_done  = 1'b1;
                    w_done_status = ST_OK;
                end
            end
            S_DONE: begin
                if (bus.done_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Job registers; TPU dimensions only change when a real launch follows,
    // so they hold their last value across IDLE and zero-dimension rejects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tpu_k   <= '0;
            r_tpu_m   <= '0;
            r_tpu_n   <= '0;
            r_job_tag <= '0;
        end else if (w_pop) begin
            r_job_tag <= w_head_tag;
            if (!w_head_zero) begin
                r_tpu_k <= w_head_k;
                r_tpu_m <= w_head_m;
                r_tpu_n <= w_head_n;
            end
        end
    end

    // Acknowledge timeout counter, restarted at each launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_ack_cnt <= '0;
        end else if ((r_state == S_WAIT_ACK) && (r_ack_cnt != c_ack_last)) begin
            r_ack_cnt <= r_ack_cnt + c_ack_w'(1);
        end
    end

    // Completion record fields, captured as the FSM enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_tag    <= '0;
            r_done_status <= ST_OK;
        end else if (w_enter_done) begin
            r_done_tag    <= (r_state == S_IDLE) ? w_head_tag : r_job_tag;
            r_done_status <= w_done_status;
        end
    end

`ifdef TPU_SCHED_PERF_EN
    logic [c_perf_w-1:0] r_perf_cnt;
    logic [c_perf_w-1:0] r_done_cycles;

    // Launch-to-completion counter; the final WAIT_ACK/RUN cycle is
    // included in the latched value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cnt    <= '0;
            r_done_cycles <= '0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_perf_cnt <= '0;
            end else if ((r_state == S_WAIT_ACK) || (r_state == S_RUN)) begin
                r_perf_cnt <= sat_inc(r_perf_cnt);
            end
            if (w_enter_done) begin
                r_done_cycles <= (r_state == S_IDLE) ? '0 : sat_inc(r_perf_cnt);
            end
        end
    end

    assign bus.done_cycles = r_done_cycles;
`else
    assign bus.done_cycles = '0;
`endif

    assign bus.cmd_ready    = !w_fifo_full;
    assign bus.tpu_in_valid = (r_state == S_LAUNCH);
    assign bus.tpu_k        = r_tpu_k;
    assign bus.tpu_m        = r_tpu_m;
    assign bus.tpu_n        = r_tpu_n;
    assign bus.done_valid   = (r_state == S_DONE);
    assign bus.done_tag     = r_done_tag;
    assign bus.done_status  = r_done_status;
    assign bus.pending      = w_fifo_count;
    assign bus.sched_idle   = (r_state == S_IDLE) && w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_tpu_job_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tpu_job_sched
//  Description : Directed self-checking bench for tpu_job_sched with a small
//                behavioural TPU (busy rises one cycle after in_valid and
//                stays high for run_len cycles, or never rises).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_job_sched;
    localparam int CMD_DEPTH   = 4;
    localparam int TAG_W       = 4;
    localparam int ACK_TIMEOUT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tpu_job_sched_if #(.CMD_DEPTH(CMD_DEPTH), .TAG_W(TAG_W)) bus ();

    tpu_job_sched #(
        .CMD_DEPTH   (CMD_DEPTH),
        .TAG_W       (TAG_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_launch = 0;
    int   max_pend = 0;
    int   run_len  = 20;
    int   busy_cnt;
    logic no_ack   = 1'b0;
    logic [TAG_W-1:0] q_tag [$];
    logic [1:0]       q_st  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cyc(input int v);
`ifdef TPU_SCHED_PERF_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Behavioural TPU
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tpu_busy <= 1'b0;
            busy_cnt     <= 0;
        end else if (bus.tpu_in_valid && !no_ack) begin
            bus.tpu_busy <= 1'b1;
            busy_cnt     <= run_len;
        end else if (bus.tpu_busy) begin
            if (busy_cnt <= 1) bus.tpu_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Monitor: launches, completion records, peak occupancy, launch-while-busy
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tpu_in_valid) begin
                n_launch <= n_launch + 1;
                check("launch_while_busy", 32'(bus.tpu_busy), 0);
            end
            if (bus.done_valid && bus.done_ready) begin
                q_tag.push_back(bus.done_tag);
                q_st.push_back(bus.done_status);
            end
            if (int'(bus.pending) > max_pend) max_pend <= int'(bus.pending);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input int m, input int n, input int tag);
        int w = 0;
        bus.cmd_k     = 8'(k);
        bus.cmd_m     = 8'(m);
        bus.cmd_n     = 8'(n);
        bus.cmd_tag   = TAG_W'(tag);
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) check("push_wait", 0, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int w = 0;
        while (!bus.done_valid && w < lim) begin
            tick();
            w++;
        end
        check("done_seen", 32'(bus.done_valid), 1);
    endtask

    task automatic wait_recs(input int n, input int lim);
        int w = 0;
        while (q_tag.size() < n && w < lim) begin
            tick();
            w++;
        end
        check("rec_count", q_tag.size(), n);
    endtask

    task automatic check_rec(input int idx, input int tag, input int st);
        logic [TAG_W-1:0] t;
        logic [1:0]       s;
        t = (idx < q_tag.size()) ? q_tag[idx] : '1;
        s = (idx < q_st.size())  ? q_st[idx]  : 2'd3;
        check($sformatf("rec%0d_tag", idx), 32'(t), tag);
        check($sformatf("rec%0d_st", idx), 32'(s), st);
    endtask

    task automatic clear_recs();
        q_tag.delete();
        q_st.delete();
    endtask

    initial begin
        int l0;
        int l1;
        int w;
        bus.cmd_valid  = 1'b0;
        bus.cmd_k      = '0;
        bus.cmd_m      = '0;
        bus.cmd_n      = '0;
        bus.cmd_tag    = '0;
        bus.done_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_sched_idle", 32'(bus.sched_idle), 1);
        check("rst_in_valid", 32'(bus.tpu_in_valid), 0);
        check("rst_tpu_k", 32'(bus.tpu_k), 0);
        check("rst_done_valid", 32'(bus.done_valid), 0);
        check("rst_done_tag", 32'(bus.done_tag), 0);
        check("rst_done_cycles", 32'(bus.done_cycles), 0);
        check("rst_pending", 32'(bus.pending), 0);
        rst_n = 1'b1;
        tick();

        // Single job: K=8 M=4 N=4 tag=3, TPU busy for 20 cycles
        run_len = 20;
        push(8, 4, 4, 3);
        check("t1_inv_t1", 32'(bus.tpu_in_valid), 0);
        check("t1_pending", 32'(bus.pending), 1);
        tick();
        check("t1_inv_t2", 32'(bus.tpu_in_valid), 1);
        check("t1_k", 32'(bus.tpu_k), 8);
        check("t1_m", 32'(bus.tpu_m), 4);
        check("t1_n", 32'(bus.tpu_n), 4);
        tick();
        check("t1_inv_pulse", 32'(bus.tpu_in_valid), 0);
        wait_done(60);
        check("t1_tag", 32'(bus.done_tag), 3);
        check("t1_status", 32'(bus.done_status), 0);
        check("t1_cycles", 32'(bus.done_cycles), exp_cyc(21));
        check("t1_k_hold", 32'(bus.tpu_k), 8);
        tick();
        check("t1_done_clr", 32'(bus.done_valid), 0);
        check("t1_idle", 32'(bus.sched_idle), 1);
        check("t1_launches", n_launch, 1);
        wait_recs(1, 5);
        check_rec(0, 3, 0);
        clear_recs();

        // Zero-dimension reject held in DONE while 4 jobs fill the FIFO, then a 5th
        bus.done_ready = 1'b0;
        run_len = 3;
        max_pend = 0;
        l0 = n_launch;
        push(5, 0, 3, 7);
        wait_done(10);
        check("z_status", 32'(bus.done_status), 1);
        check("z_tag", 32'(bus.done_tag), 7);
        check("z_cycles", 32'(bus.done_cycles), 0);
        check("z_k_hold", 32'(bus.tpu_k), 8);
        for (int i = 0; i < 4; i++) push(2, 3, 4, i);
        check("f_pending_full", 32'(bus.pending), 4);
        check("f_cmd_ready", 32'(bus.cmd_ready), 0);
        check("z_no_launch", n_launch - l0, 0);
        check("z_tag_hold", 32'(bus.done_tag), 7);
        bus.done_ready = 1'b1;
        push(2, 3, 4, 4);
        wait_recs(6, 300);
        check_rec(0, 7, 1);
        for (int i = 0; i < 5; i++) check_rec(i + 1, i, 0);
        check("f_launches", n_launch - l0, 5);
        check("f_max_pend", max_pend, 4);
        clear_recs();

        // Acknowledge timeout, then the queued job runs normally
        bus.done_ready = 1'b0;
        no_ack = 1'b1;
        l0 = n_launch;
        push(1, 1, 1, 5);
        push(1, 1, 1, 6);
        w = 0;
        while (!bus.tpu_in_valid && w < 10) begin
            tick();
            w++;
        end
        check("to_launch", 32'(bus.tpu_in_valid), 1);
        w = 0;
        while (!bus.done_valid && w < 20) begin
            tick();
            w++;
        end
        check("to_latency", w, 1 + ACK_TIMEOUT);
        check("to_status", 32'(bus.done_status), 2);
        check("to_tag", 32'(bus.done_tag), 5);
        check("to_cycles", 32'(bus.done_cycles), exp_cyc(ACK_TIMEOUT));
        check("to_pending", 32'(bus.pending), 1);
        no_ack = 1'b0;
        repeat (2) tick();
        check("to_hold_launch", n_launch - l0, 1);
        bus.done_ready = 1'b1;
        wait_recs(2, 100);
        check_rec(0, 5, 2);
        check_rec(1, 6, 0);
        check("to_launches", n_launch - l0, 2);
        clear_recs();

        // Consumer stall with two jobs queued; push+pop in the same cycle
        bus.done_ready = 1'b0;
        l0 = n_launch;
        push(3, 3, 3, 1);
        push(3, 3, 3, 2);
        push(3, 3, 3, 3);
        wait_done(50);
        check("s_pending", 32'(bus.pending), 2);
        l1 = n_launch;
        check("s_launch1", l1 - l0, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s_valid_hold", 32'(bus.done_valid), 1);
            check("s_tag_hold", 32'(bus.done_tag), 1);
            check("s_status_hold", 32'(bus.done_status), 0);
            check("s_no_launch", n_launch, l1);
        end
        bus.done_ready = 1'b1;
        tick();
        check("s_pend_pre", 32'(bus.pending), 2);
        bus.cmd_k     = 8'd3;
        bus.cmd_m     = 8'd3;
        bus.cmd_n     = 8'd3;
        bus.cmd_tag   = TAG_W'(4);
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        check("s_pushpop_pending", 32'(bus.pending), 2);
        check("s_pushpop_launch", 32'(bus.tpu_in_valid), 1);
        wait_recs(4, 200);
        for (int i = 0; i < 4; i++) check_rec(i, i + 1, 0);
        clear_recs();

        // Asynchronous reset in the middle of RUN
        run_len = 20;
        l0 = n_launch;
        push(4, 4, 4, 8);
        push(4, 4, 4, 9);
        repeat (4) tick();
        check("r_pending_pre", 32'(bus.pending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_in_valid", 32'(bus.tpu_in_valid), 0);
        check("r_done_valid", 32'(bus.done_valid), 0);
        check("r_tpu_k", 32'(bus.tpu_k), 0);
        check("r_pending", 32'(bus.pending), 0);
        check("r_cmd_ready", 32'(bus.cmd_ready), 1);
        check("r_sched_idle", 32'(bus.sched_idle), 1);
        check("r_done_tag", 32'(bus.done_tag), 0);
        check("r_done_cycles", 32'(bus.done_cycles), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("r_no_record", q_tag.size(), 0);
        check("r_launches", n_launch - l0, 1);
        check("r_idle_after", 32'(bus.sched_idle), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
